// File: rtl/mw_adder_pkg.sv
// rtl/mw_adder_pkg.sv - shared types and defaults for the multi-word add/subtract sequencer
package mw_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mw_state_t;

    localparam int MW_W       = 16;
    localparam int MW_N_WORDS = 4;
    localparam int IDX_W      = $clog2(MW_N_WORDS);

endpackage

// File: rtl/par_posl_adder_param.sv
// rtl/par_posl_adder_param.sv - W-bit adder with carry in and carry out
module par_posl_adder_param #(
    parameter int W = 16
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
    output logic [W-1:0] S,
    output logic         C_out
);

    logic [W:0] sum;

    assign sum   = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, C_in};
    assign S     = sum[W-1:0];
    assign C_out = sum[W];

endmodule

// File: rtl/mw_adder_seq.sv
// rtl/mw_adder_seq.sv - N_WORDS x W add/subtract, one slice per clock through a shared W-bit adder
module mw_adder_seq
    import mw_adder_pkg::*;
#(
    parameter int W       = MW_W,
    parameter int N_WORDS = MW_N_WORDS
) (
    input  logic                 CLK_i,
    input  logic                 rst_n_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 sub_i,
    input  logic [N_WORDS*W-1:0] A_i,
    input  logic [N_WORDS*W-1:0] B_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [N_WORDS*W-1:0] S_o,
    output logic                 C_o,
    output logic                 V_o
);

    localparam int IDX_BITS = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_WORDS - 1);

    mw_state_t state_q, state_d;

    logic [IDX_BITS-1:0]  idx_q;
    logic                 carry_q;
    logic                 sub_q;
    logic [N_WORDS*W-1:0] a_q, b_q, s_q;
    logic                 c_q, v_q;

    logic [W-1:0] a_slice, b_slice, add_s;
    logic         add_c;
    logic         last_slice;
    logic         slice_ovf;

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry loaded at accept.
    assign a_slice    = a_q[int'(idx_q)*W +: W];
    assign b_slice    = b_q[int'(idx_q)*W +: W] ^ {W{sub_q}};
    assign last_slice = (idx_q == LAST_IDX);
    assign slice_ovf  = (a_slice[W-1] == b_slice[W-1]) && (add_s[W-1] != a_slice[W-1]);

    par_posl_adder_param #(.W(W)) u_adder (
        .A     (a_slice),
        .B     (b_slice),
        .C_in  (carry_q),
        .S     (add_s),
        .C_out (add_c)
    );

    always_ff @(posedge CLK_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i)    state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (ready_i)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    always_ff @(posedge CLK_i) begin
        if (!rst_n_i) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= A_i;
                        b_q     <= B_i;
                        sub_q   <= sub_i;
                        idx_q   <= '0;
                        carry_q <= sub_i;
                    end
                end
                RUN: begin
                    s_q[int'(idx_q)*W +: W] <= add_s;
                    carry_q <= add_c;
                    idx_q   <= idx_q + 1'b1;
                    if (last_slice) begin
                        c_q <= add_c;
                        v_q <= slice_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_o = s_q;
    assign C_o = c_q;
    assign V_o = v_q;

endmodule

// File: tb/tb_mw_adder_seq.sv
// tb/tb_mw_adder_seq.sv - randomized self-checking bench for mw_adder_seq
module tb_mw_adder_seq;

    localparam int W       = 16;
    localparam int N_WORDS = 4;
    localparam int XW      = W * N_WORDS;

    logic          CLK_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          sub_i = 1'b0;
    logic [XW-1:0] A_i = '0;
    logic [XW-1:0] B_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [XW-1:0] S_o;
    logic          C_o;
    logic          V_o;

    int n_checks = 0;
    int n_errors = 0;

    mw_adder_seq #(.W(W), .N_WORDS(N_WORDS)) dut (
        .CLK_i   (CLK_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sub_i   (sub_i),
        .A_i     (A_i),
        .B_i     (B_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .S_o     (S_o),
        .C_o     (C_o),
        .V_o     (V_o)
    );

    always #5 CLK_i = ~CLK_i;

    task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    function automatic logic [XW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // Reference: full-width arithmetic, carry from bit XW, overflow from operand/result signs.
    function automatic logic [XW+1:0] model(input logic [XW-1:0] a, input logic [XW-1:0] b, input logic sub);
        logic [XW:0] full;
        logic        v;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + (XW+1)'(1);
            v    = (a[XW-1] != b[XW-1]) && (full[XW-1] != a[XW-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            v    = (a[XW-1] == b[XW-1]) && (full[XW-1] != a[XW-1]);
        end
        return {v, full};
    endfunction

    task automatic run_op(input string tag, input logic [XW-1:0] a, input logic [XW-1:0] b,
                          input logic sub, input int stall);
        logic [XW+1:0] exp;
        int            k;
        exp = model(a, b, sub);
        k = 0;
        while (!ready_o && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_ready"}, XW'(ready_o), XW'(1));
        valid_i = 1'b1;
        A_i     = a;
        B_i     = b;
        sub_i   = sub;
        tick();
        valid_i = 1'b0;
        A_i     = rand_word();
        B_i     = rand_word();
        sub_i   = ~sub;
        k = 0;
        while (!valid_o && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_latency"}, XW'(k), XW'(N_WORDS));
        check({tag, "_S"}, S_o, exp[XW-1:0]);
        check({tag, "_C"}, XW'(C_o), XW'(exp[XW]));
        check({tag, "_V"}, XW'(V_o), XW'(exp[XW+1]));
        for (int i = 0; i < stall; i++) begin
            valid_i = i[0];
            A_i     = rand_word();
            B_i     = rand_word();
            tick();
            check({tag, "_hold_valid"}, XW'(valid_o), XW'(1));
            check({tag, "_hold_ready"}, XW'(ready_o), XW'(0));
            check({tag, "_hold_S"}, S_o, exp[XW-1:0]);
            check({tag, "_hold_CV"}, XW'({V_o, C_o}), XW'(exp[XW+1:XW]));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({tag, "_hs_valid"}, XW'(valid_o), XW'(0));
        check({tag, "_hs_ready"}, XW'(ready_o), XW'(1));
    endtask

    initial begin
        rst_n_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        check("rst_ready", XW'(ready_o), XW'(1));
        check("rst_valid", XW'(valid_o), XW'(0));
        check("rst_S", S_o, '0);
        check("rst_CV", XW'({V_o, C_o}), XW'(0));

        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 0);
        run_op("sub_borrow", 64'h0, 64'h1, 1'b1, 0);
        run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
        run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 0);
        run_op("backpressure", 64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b1, 5);
        run_op("after_bp", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 0);

        valid_i = 1'b1;
        A_i     = 64'hAAAA_AAAA_AAAA_AAAA;
        B_i     = 64'h5555_5555_5555_5555;
        sub_i   = 1'b0;
        tick();
        valid_i = 1'b0;
        tick();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        check("midrst_ready", XW'(ready_o), XW'(1));
        check("midrst_valid", XW'(valid_o), XW'(0));
        check("midrst_S", S_o, '0);
        check("midrst_CV", XW'({V_o, C_o}), XW'(0));
        run_op("post_rst", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 0);
        check("post_rst_const", S_o, 64'h2222_2222_2222_2211);

        for (int n = 0; n < 4000; n++) begin
            logic [XW-1:0] a, b;
            a = rand_word();
            b = rand_word();
            if ($urandom_range(0, 15) == 0) a = {1'b0, {(XW-1){1'b1}}};
            if ($urandom_range(0, 15) == 0) b = {$urandom_range(0, 1) == 1, {(XW-1){1'b0}}};
            run_op("rand", a, b, $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
